// File: rtl/dcache_flush_ctrl.sv
// Data-cache flush sequencer: walks every line, writes valid+dirty lines back
// word by word, clears their dirty bits and stalls store commit meanwhile.
module dcache_flush_ctrl #(
  parameter int NUM_LINES  = 64,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  localparam int IDX_W     = $clog2(NUM_LINES),
  localparam int OFF_W     = $clog2(LINE_WORDS),
  localparam int TAG_W     = ADDR_W - IDX_W - OFF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_req,
  output logic [IDX_W-1:0]  line_idx,
  input  logic              line_vld,
  input  logic              line_dirty,
  input  logic [TAG_W-1:0]  line_tag,
  output logic [OFF_W-1:0]  word_sel,
  input  logic [DATA_W-1:0] word_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_wr_rdy,
  output logic              clr_dirty_en,
  output logic [IDX_W-1:0]  clr_idx,
  output logic              st_stall,
  output logic              flush_busy,
  output logic              flush_done,
  output logic [IDX_W:0]    wb_lines
);

  localparam logic [IDX_W-1:0] LAST_LINE = IDX_W'(NUM_LINES - 1);
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, CHECK, WRITE, CLEAR, DONE} state_t;

  state_t           state, next_state;
  logic [IDX_W-1:0] ptr;
  logic [OFF_W-1:0] cnt;
  logic             req_q;
  logic             start;
  logic             last_line;

  assign start     = flush_req && !req_q;
  assign last_line = (ptr == LAST_LINE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Walk pointer, word counter, request edge register and write-back tally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      cnt      <= '0;
      req_q    <= 1'b0;
      wb_lines <= '0;
    end else begin
      req_q <= flush_req;
      case (state)
        IDLE: begin
          if (start) begin
            ptr      <= '0;
            wb_lines <= '0;
          end
        end
        CHECK: begin
          if (line_vld && line_dirty) cnt <= '0;
          else if (!last_line)        ptr <= ptr + IDX_W'(1);
        end
        WRITE: begin
          if (mem_wr_rdy) cnt <= cnt + OFF_W'(1);
        end
        CLEAR: begin
          wb_lines <= wb_lines + (IDX_W+1)'(1);
          if (!last_line) ptr <= ptr + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state   = state;
    line_idx     = '0;
    word_sel     = '0;
    mem_wr_en    = 1'b0;
    mem_wr_addr  = '0;
    mem_wr_data  = '0;
    clr_dirty_en = 1'b0;
    clr_idx      = '0;
    st_stall     = 1'b0;
    flush_busy   = 1'b0;
    flush_done   = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = CHECK;
      end
      CHECK: begin
        st_stall   = 1'b1;
        flush_busy = 1'b1;
        line_idx   = ptr;
        if (line_vld && line_dirty) next_state = WRITE;
        else if (last_line)         next_state = DONE;
      end
      WRITE: begin
        st_stall    = 1'b1;
        flush_busy  = 1'b1;
        line_idx    = ptr;
        word_sel    = cnt;
        mem_wr_en   = 1'b1;
        mem_wr_addr = {line_tag, ptr, cnt};
        mem_wr_data = word_data;
        if (mem_wr_rdy && cnt == LAST_WORD) next_state = CLEAR;
      end
      CLEAR: begin
        st_stall     = 1'b1;
        flush_busy   = 1'b1;
        line_idx     = ptr;
        clr_dirty_en = 1'b1;
        clr_idx      = ptr;
        next_state   = last_line ? DONE : CHECK;
      end
      DONE: begin
        st_stall   = 1'b1;
        flush_done = 1'b1;
        if (!flush_req) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
